if_stage_prefetch: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues requests to instruction memory over a req/ack handshake with at most one request outstanding.
- Buffers returned words in a small prefetch queue and drives the IF/ID pipeline register (Instruction, PC, valid) consumed by decode.
- Honours the hazard freeze and branch redirects; a redirect flushes both the queue and any in-flight response.

---
 rtl/if_stage_prefetch.sv | 130 +++++++++++++
 tb/tb_if_stage_prefetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding req/ack fetch FSM,
// buffers returned words in a small FIFO and drives the IF/ID register.
module if_stage_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        instr_valid
);

    // state | meaning
    // IDLE  | no request outstanding; issue when the queue has room
    // WAIT  | request outstanding, response will be pushed
    // DROP  | request outstanding, response will be discarded (redirected)
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [31:0] RST_PC_A = {RESET_PC[31:2], 2'b00};

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          q_empty;
    logic          q_full;
    logic          push;
    logic          pop;
    logic [31:0]   target;

    assign target  = {Branch_Address[31:2], 2'b00};
    assign q_empty = (count == '0);
    assign q_full  = (count == FULL_CNT);
    assign push    = !rst && (state == WAIT) && imem_ack && !Branch_taken;
    assign pop     = !Branch_taken && !freeze && !q_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RST_PC_A;
            imem_req  <= 1'b0;
            imem_addr <= RST_PC_A;
        end else begin
            case (state)
                IDLE: begin
                    if (Branch_taken) begin
                        fetch_pc <= target;
                    end else if (!q_full) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (Branch_taken) begin
                        fetch_pc <= target;
                        imem_req <= 1'b0;
                        state    <= imem_ack ? IDLE : DROP;
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DROP: begin
                    // a further redirect while draining just retargets
                    if (Branch_taken) fetch_pc <= target;
                    if (imem_ack)     state    <= IDLE;
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || Branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // IF/ID register: no bypass from imem_rdata, words always pass through the queue
    always_ff @(posedge clk) begin
        if (rst || Branch_taken) begin
            Instruction <= 32'h0;
            PC          <= 32'h0;
            instr_valid <= 1'b0;
        end else if (!freeze) begin
            if (!q_empty) begin
                Instruction <= q_instr[rd_ptr];
                PC          <= q_pc[rd_ptr];
                instr_valid <= 1'b1;
            end else begin
                Instruction <= 32'h0;
                PC          <= 32'h0;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Self-checking bench for if_stage_prefetch: memory model plus a queue-of-addresses
// reference for the IF/ID stream, directed scenarios followed by random traffic.
module tb_if_stage_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        br;
    logic [31:0] ba;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        instr_valid;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    logic [31:0] e_instr, e_pc;
    logic        e_valid;
    logic [31:0] exp_req_addr;
    logic [31:0] req_addr;
    bit          outstanding = 0;
    bit          dropped = 0;
    int          lat_cnt;
    int          lat = 1;
    bit          rand_lat = 0;
    int          pops_seen = 0;

    if_stage_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .Branch_taken(br), .Branch_Address(ba),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(ack), .imem_rdata(rdata),
        .Instruction(Instruction), .PC(PC), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hE000_0000 + (a >> 2) + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: update the reference with this cycle's inputs, cross the edge,
    // compare, then drive the memory response for the new cycle.
    task automatic step();
        int          pre_size;
        bit          live_ack;
        logic [31:0] a;
        pre_size = q.size();
        if (rst) begin
            q.delete();
            e_instr = 0; e_pc = 0; e_valid = 0;
            exp_req_addr = RESET_PC;
            outstanding = 0; dropped = 0;
        end else begin
            live_ack = ack && outstanding && !dropped && !br;
            if (br) begin
                q.delete();
                e_instr = 0; e_pc = 0; e_valid = 0;
                exp_req_addr = {ba[31:2], 2'b00};
            end else begin
                if (!freeze) begin
                    if (q.size() > 0) begin
                        a = q.pop_front();
                        e_instr = word_at(a); e_pc = a + 32'd4; e_valid = 1;
                        pops_seen++;
                    end else begin
                        e_instr = 0; e_pc = 0; e_valid = 0;
                    end
                end
                if (live_ack) begin
                    q.push_back(req_addr);
                    exp_req_addr = req_addr + 32'd4;
                end
            end
            if (ack) outstanding = 0;
            else if (br && outstanding) dropped = 1;
        end

        @(posedge clk); #1;

        check("instr", Instruction, e_instr);
        check("pc", PC, e_pc);
        check("valid", {31'b0, instr_valid}, {31'b0, e_valid});
        check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        ack = 1'b0;
        rdata = $urandom;
        if (rst) begin
            check("rst_req", {31'b0, imem_req}, 32'h0);
            check("rst_addr", imem_addr, RESET_PC);
        end else if (!outstanding) begin
            if (imem_req) begin
                check("req_addr", imem_addr, exp_req_addr);
                check("issue_room", {31'b0, (pre_size < DEPTH)}, 32'h1);
                outstanding = 1; dropped = 0;
                req_addr = imem_addr;
                lat_cnt = rand_lat ? $urandom_range(1, 4) : lat;
            end
        end else begin
            check("req_level", {31'b0, imem_req}, {31'b0, !dropped});
            if (!dropped) check("addr_stable", imem_addr, req_addr);
            lat_cnt--;
            if (lat_cnt == 0) begin
                ack = 1'b1;
                rdata = word_at(req_addr);
            end
        end
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (!instr_valid && n < bound) begin step(); n++; end
        check(tag, {31'b0, instr_valid}, 32'h1);
    endtask

    task automatic wait_req(input string tag, input int bound);
        int n = 0;
        while (!(imem_req && !ack) && n < bound) begin step(); n++; end
        check(tag, {31'b0, (imem_req && !ack)}, 32'h1);
    endtask

    task automatic wait_live_ack(input string tag, input int bound);
        int n = 0;
        while (!(ack && !dropped) && n < bound) begin step(); n++; end
        check(tag, {31'b0, (ack && !dropped)}, 32'h1);
    endtask

    initial begin
        int p0;
        rst = 1; freeze = 0; br = 0; ba = 0; ack = 0; rdata = 0;
        step(); step();
        check("reset_valid", {31'b0, instr_valid}, 32'h0);
        rst = 0;

        // first words at latency 1
        lat = 1;
        wait_valid("first_valid_timeout", 20);
        check("first_instr", Instruction, 32'hE000_0001);
        check("first_pc", PC, 32'h4);
        step(); step(); step();
        check("second_valid", {31'b0, instr_valid}, 32'h1);
        check("second_pc", PC, 32'h8);

        // freeze long enough to fill the queue, then drain
        freeze = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("freeze_hold_pc", PC, 32'h8);
            check("freeze_hold_instr", Instruction, 32'hE000_0002);
            if (i >= 15) check("full_no_req", {31'b0, imem_req}, 32'h0);
        end
        freeze = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("drain_valid", {31'b0, instr_valid}, 32'h1);
            check("drain_pc", PC, 32'hC + 32'(4 * k));
        end

        // redirect while a latency-3 request is outstanding
        lat = 3;
        wait_req("wait_state_timeout", 20);
        br = 1; ba = 32'h0000_0103;
        step();
        br = 0;
        check("br_bubble", {31'b0, instr_valid}, 32'h0);
        check("br_drop_req", {31'b0, imem_req}, 32'h0);
        wait_valid("br_target_timeout", 40);
        check("br_target_pc", PC, 32'h104);
        check("br_target_instr", Instruction, word_at(32'h100));

        // redirect coincident with an ack, under freeze
        lat = 2;
        wait_valid("pre_freeze_valid", 20);
        freeze = 1;
        wait_live_ack("ack_timeout", 20);
        br = 1; ba = 32'h0000_0200;
        step();
        br = 0; freeze = 0;
        check("br_ack_bubble_valid", {31'b0, instr_valid}, 32'h0);
        check("br_ack_bubble_instr", Instruction, 32'h0);
        wait_req("br_ack_req_timeout", 20);
        check("br_ack_req_addr", imem_addr, 32'h200);

        // repeated fill/drain across pointer wrap
        lat = 1;
        p0 = pops_seen;
        for (int r = 0; r < 3; r++) begin
            freeze = 1;
            for (int i = 0; i < 20; i++) step();
            freeze = 0;
            for (int i = 0; i < 10; i++) step();
        end
        check("wrap_delivered", {31'b0, ((pops_seen - p0) >= 12)}, 32'h1);

        // reset in the middle of a request
        lat = 3;
        wait_req("rst_wait_timeout", 20);
        rst = 1;
        step();
        rst = 0;
        check("rst_mid_valid", {31'b0, instr_valid}, 32'h0);
        wait_req("rst_restart_timeout", 10);
        check("rst_restart_addr", imem_addr, RESET_PC);
        wait_valid("rst_restart_valid", 20);
        check("rst_restart_pc", PC, RESET_PC + 32'd4);

        // random traffic
        rand_lat = 1;
        for (int i = 0; i < 1500; i++) begin
            freeze = ($urandom_range(0, 3) == 0);
            br     = ($urandom_range(0, 11) == 0) && !(ack && dropped);
            ba     = $urandom & 32'h0000_0FFF;
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; br = 0; freeze = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
